// File: rtl/microroc_sc_pkg.sv
// Shared definitions for the Microroc slow-control / read-register loader:
// FSM encoding, frame lengths, SC frame field offsets and frame builders.
package microroc_sc_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    RESET_CHAIN = 2'd1,
    SHIFT       = 2'd2,
    DONE        = 2'd3
  } sc_state_e;

  localparam int SC_LENGTH = 286;
  localparam int RR_LENGTH = 64;

  // LSB position of each field inside the SC frame; bit SC_LENGTH-1 leaves first.
  localparam int DAC0_LSB  = 0;
  localparam int DAC1_LSB  = 10;
  localparam int DAC2_LSB  = 20;
  localparam int MASK_LSB  = 30;
  localparam int CTEST_LSB = 222;

  function automatic logic [SC_LENGTH-1:0] sc_frame(input logic [63:0]  ctest,
                                                    input logic [191:0] mask,
                                                    input logic [9:0]   dac2,
                                                    input logic [9:0]   dac1,
                                                    input logic [9:0]   dac0);
    logic [SC_LENGTH-1:0] f;
    f = '0;
    f[CTEST_LSB +: 64] = ctest;
    f[MASK_LSB +: 192] = mask;
    f[DAC2_LSB +: 10]  = dac2;
    f[DAC1_LSB +: 10]  = dac1;
    f[DAC0_LSB +: 10]  = dac0;
    return f;
  endfunction

  // The RR frame is MSB-aligned so both modes shift out of the same top bit.
  function automatic logic [SC_LENGTH-1:0] rr_frame(input logic [63:0] rr);
    logic [SC_LENGTH-1:0] f;
    f = '0;
    f[SC_LENGTH-1 -: RR_LENGTH] = rr;
    return f;
  endfunction

endpackage

// File: rtl/microroc_sc_loader_if.sv
// Controller-side parameter inputs and ASIC-side shift-chain outputs of the loader.
interface microroc_sc_loader_if;
  logic         SCParameterLoad;
  logic         SCOrReadreg;
  logic [9:0]   Microroc10BitDac0;
  logic [9:0]   Microroc10BitDac1;
  logic [9:0]   Microroc10BitDac2;
  logic [191:0] MicrorocChannelMask;
  logic [63:0]  MicrorocCTestChannel;
  logic [63:0]  ReadregChannel;
  logic         SR_SELECT;
  logic         SR_RSTB;
  logic         SR_CK;
  logic         SR_IN;
  logic         Busy;
  logic         MicrorocConfigDone;

  modport master (
    output SCParameterLoad, SCOrReadreg, Microroc10BitDac0, Microroc10BitDac1,
           Microroc10BitDac2, MicrorocChannelMask, MicrorocCTestChannel, ReadregChannel,
    input  SR_SELECT, SR_RSTB, SR_CK, SR_IN, Busy, MicrorocConfigDone
  );

  modport slave (
    input  SCParameterLoad, SCOrReadreg, Microroc10BitDac0, Microroc10BitDac1,
           Microroc10BitDac2, MicrorocChannelMask, MicrorocCTestChannel, ReadregChannel,
    output SR_SELECT, SR_RSTB, SR_CK, SR_IN, Busy, MicrorocConfigDone
  );
endinterface

// File: rtl/sc_clk_phase_gen.sv
// SR_CK phase generator: HALF_PERIOD cycles low then HALF_PERIOD cycles high per bit,
// with strobes on the first low cycle and the last high cycle; idles low when disabled.
module sc_clk_phase_gen #(
  parameter int HALF_PERIOD = 2
) (
  input  logic Clk,
  input  logic reset_n,
  input  logic en,
  output logic ck,
  output logic bit_start,
  output logic bit_end
);

  logic [7:0] cnt_r;
  logic       phase_r;
  logic       last_s;

  assign last_s = (cnt_r == 8'(HALF_PERIOD - 1));

  // Half-period counter and phase bit
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r   <= 8'd0;
      phase_r <= 1'b0;
    end else if (!en) begin
      cnt_r   <= 8'd0;
      phase_r <= 1'b0;
    end else if (last_s) begin
      cnt_r   <= 8'd0;
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + 8'd1;
    end
  end

  assign ck        = phase_r;
  assign bit_start = en & ~phase_r & (cnt_r == 8'd0);
  assign bit_end   = en & phase_r & last_s;

endmodule

// File: rtl/microroc_sc_loader.sv
// Latches the DAC/mask/CTest or read-register parameters on a load request and
// serializes them MSB first into the Microroc shift chain, then pulses ConfigDone.
module microroc_sc_loader
  import microroc_sc_pkg::*;
#(
  parameter int HALF_PERIOD = 2,
  parameter int RST_CYCLES  = 8
) (
  input  logic                 Clk,
  input  logic                 reset_n,
  microroc_sc_loader_if.slave  bus
);

  sc_state_e            state_r, state_s;
  logic                 load_q_r, armed_r, req_s, accept_s;
  logic [7:0]           rst_cnt_r;
  logic [8:0]           bit_cnt_r;
  logic [SC_LENGTH-1:0] frame_r;
  logic                 sel_r, rstb_r, busy_r, done_r;
  logic                 sr_ck_s, bit_end_s, unused_bit_start_s;

  // armed_r keeps a level held high across reset from looking like a fresh edge.
  assign req_s    = bus.SCParameterLoad & ~load_q_r & armed_r;
  assign accept_s = (state_r == IDLE) & req_s;

  // Load request edge detector
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      load_q_r <= 1'b0;
      armed_r  <= 1'b0;
    end else begin
      load_q_r <= bus.SCParameterLoad;
      armed_r  <= armed_r | ~bus.SCParameterLoad;
    end
  end

  // FSM state register
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) state_s = RESET_CHAIN;
        else       state_s = IDLE;
      end
      RESET_CHAIN: begin
        if (rst_cnt_r == 8'(RST_CYCLES - 1)) state_s = SHIFT;
        else                                 state_s = RESET_CHAIN;
      end
      SHIFT: begin
        if (bit_end_s && (bit_cnt_r == 9'd0)) state_s = DONE;
        else                                  state_s = SHIFT;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_r  <= 1'b1;
      rstb_r <= 1'b1;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      rstb_r <= (state_s != RESET_CHAIN);
      busy_r <= (state_s == RESET_CHAIN) || (state_s == SHIFT);
      done_r <= (state_s == DONE);
      if (accept_s) sel_r <= bus.SCOrReadreg;
    end
  end

  // Shadow frame, chain-reset counter and bit counter
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_r   <= '0;
      rst_cnt_r <= 8'd0;
      bit_cnt_r <= 9'd0;
    end else if (accept_s) begin
      frame_r   <= bus.SCOrReadreg ?
                   sc_frame(bus.MicrorocCTestChannel, bus.MicrorocChannelMask,
                            bus.Microroc10BitDac2, bus.Microroc10BitDac1,
                            bus.Microroc10BitDac0) :
                   rr_frame(bus.ReadregChannel);
      rst_cnt_r <= 8'd0;
    end else if (state_r == RESET_CHAIN) begin
      rst_cnt_r <= rst_cnt_r + 8'd1;
      bit_cnt_r <= sel_r ? 9'(SC_LENGTH - 1) : 9'(RR_LENGTH - 1);
    end else if (bit_end_s) begin
      // Zeros shift in, so SR_IN is already 0 when DONE is reached.
      frame_r <= {frame_r[SC_LENGTH-2:0], 1'b0};
      if (bit_cnt_r != 9'd0) bit_cnt_r <= bit_cnt_r - 9'd1;
    end
  end

  sc_clk_phase_gen #(.HALF_PERIOD(HALF_PERIOD)) u_phase (
    .Clk       (Clk),
    .reset_n   (reset_n),
    .en        (state_r == SHIFT),
    .ck        (sr_ck_s),
    .bit_start (unused_bit_start_s),
    .bit_end   (bit_end_s)
  );

  assign bus.SR_SELECT          = sel_r;
  assign bus.SR_RSTB            = rstb_r;
  assign bus.SR_CK              = sr_ck_s;
  assign bus.SR_IN              = frame_r[SC_LENGTH-1];
  assign bus.Busy               = busy_r;
  assign bus.MicrorocConfigDone = done_r;

endmodule

// File: tb/tb_microroc_sc_loader.sv
// Bench for microroc_sc_loader: default-timing and fast-timing instances, table of
// frames plus random vectors, checked against a queue-built frame model and latency formula.
module tb_microroc_sc_loader;
  import microroc_sc_pkg::*;

  localparam int HP_A = 2, RC_A = 8, HP_B = 1, RC_B = 1;

  typedef struct {
    int           w;
    logic         mode;
    logic [9:0]   dac0, dac1, dac2;
    logic [191:0] mask;
    logic [63:0]  ctest, rr;
    int           exp_len;
    int           exp_lat;
  } vec_t;

  int hp_arr [2] = '{HP_A, HP_B};
  int rc_arr [2] = '{RC_A, RC_B};

  logic Clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 Clk = ~Clk;

  logic         load_v [2];
  logic         mode_v;
  logic [9:0]   d0_v, d1_v, d2_v;
  logic [191:0] mask_v;
  logic [63:0]  ctest_v, rr_v;

  microroc_sc_loader_if ifa ();
  microroc_sc_loader_if ifb ();

  assign ifa.SCParameterLoad = load_v[0];
  assign ifb.SCParameterLoad = load_v[1];
  assign ifa.SCOrReadreg = mode_v;           assign ifb.SCOrReadreg = mode_v;
  assign ifa.Microroc10BitDac0 = d0_v;       assign ifb.Microroc10BitDac0 = d0_v;
  assign ifa.Microroc10BitDac1 = d1_v;       assign ifb.Microroc10BitDac1 = d1_v;
  assign ifa.Microroc10BitDac2 = d2_v;       assign ifb.Microroc10BitDac2 = d2_v;
  assign ifa.MicrorocChannelMask = mask_v;   assign ifb.MicrorocChannelMask = mask_v;
  assign ifa.MicrorocCTestChannel = ctest_v; assign ifb.MicrorocCTestChannel = ctest_v;
  assign ifa.ReadregChannel = rr_v;          assign ifb.ReadregChannel = rr_v;

  microroc_sc_loader #(.HALF_PERIOD(HP_A), .RST_CYCLES(RC_A)) dut_a (
    .Clk(Clk), .reset_n(reset_n), .bus(ifa));
  microroc_sc_loader #(.HALF_PERIOD(HP_B), .RST_CYCLES(RC_B)) dut_b (
    .Clk(Clk), .reset_n(reset_n), .bus(ifb));

  logic ck [2], sin [2], done [2], rstb [2], busy [2], sel [2];
  assign ck[0] = ifa.SR_CK;    assign ck[1] = ifb.SR_CK;
  assign sin[0] = ifa.SR_IN;   assign sin[1] = ifb.SR_IN;
  assign done[0] = ifa.MicrorocConfigDone; assign done[1] = ifb.MicrorocConfigDone;
  assign rstb[0] = ifa.SR_RSTB; assign rstb[1] = ifb.SR_RSTB;
  assign busy[0] = ifa.Busy;    assign busy[1] = ifb.Busy;
  assign sel[0] = ifa.SR_SELECT; assign sel[1] = ifb.SR_SELECT;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, captures SR_IN at each SR_CK rise
  logic         clr [2];
  logic [285:0] cap_v [2];
  int           cap_n [2], done_n [2], done_cyc [2], rstb_low [2], glitch [2];
  logic         prev_ck [2], prev_in [2], done_busy [2];
  always @(negedge Clk) begin
    for (int w = 0; w < 2; w++) begin
      prev_ck[w] <= ck[w];
      prev_in[w] <= sin[w];
      if (clr[w]) begin
        cap_v[w] <= '0; cap_n[w] <= 0; done_n[w] <= 0; done_cyc[w] <= 0;
        rstb_low[w] <= 0; glitch[w] <= 0; done_busy[w] <= 1'b0;
      end else begin
        if (ck[w] && !prev_ck[w] && cap_n[w] < 286) begin
          cap_v[w][285 - cap_n[w]] <= sin[w];
          cap_n[w] <= cap_n[w] + 1;
        end
        if (done[w]) begin
          done_n[w] <= done_n[w] + 1;
          done_cyc[w] <= cyc;
          done_busy[w] <= busy[w];
        end
        if (!rstb[w]) rstb_low[w] <= rstb_low[w] + 1;
        if (ck[w] && (sin[w] !== prev_in[w])) glitch[w] <= glitch[w] + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_frame(input string name, input logic [285:0] act, input logic [285:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_mon(input int w);
    clr[w] = 1'b1;
    tick();
    clr[w] = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    mode_v = v.mode; d0_v = v.dac0; d1_v = v.dac1; d2_v = v.dac2;
    mask_v = v.mask; ctest_v = v.ctest; rr_v = v.rr;
  endtask

  function automatic logic [5:0] outs(input int w);
    return {sel[w], rstb[w], ck[w], sin[w], busy[w], done[w]};
  endfunction

  // Reference frame: fields pushed in shift order, MSB first, into a bit queue
  function automatic logic [285:0] model_frame(input vec_t v);
    bit q[$];
    logic [285:0] r;
    if (v.mode) begin
      for (int i = 63; i >= 0; i--)  q.push_back(v.ctest[i]);
      for (int i = 191; i >= 0; i--) q.push_back(v.mask[i]);
      for (int i = 9; i >= 0; i--)   q.push_back(v.dac2[i]);
      for (int i = 9; i >= 0; i--)   q.push_back(v.dac1[i]);
      for (int i = 9; i >= 0; i--)   q.push_back(v.dac0[i]);
    end else begin
      for (int i = 63; i >= 0; i--)  q.push_back(v.rr[i]);
    end
    r = '0;
    for (int i = 0; i < q.size(); i++) r[285 - i] = q[i];
    return r;
  endfunction

  function automatic vec_t rand_vec(input int w);
    vec_t v;
    v.w = w;
    v.mode = 1'($urandom_range(0, 1));
    v.dac0 = 10'($urandom); v.dac1 = 10'($urandom); v.dac2 = 10'($urandom);
    v.mask = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    v.ctest = {$urandom, $urandom};
    v.rr = {$urandom, $urandom};
    v.exp_len = v.mode ? 286 : 64;
    v.exp_lat = 1 + rc_arr[w] + v.exp_len * 2 * hp_arr[w];
    return v;
  endfunction

  task automatic wait_idle(input int w);
    int k = 0;
    while (busy[w] && k < 3000) begin
      tick();
      k++;
    end
    check("idle_before_request", busy[w], 1'b0);
  endtask

  // One frame: raise the load (held `hold` cycles); optionally edit inputs and re-request mid-frame
  task automatic run_frame(input vec_t v, input int hold, input int edit_at);
    int w, k, done_k, c0;
    logic [285:0] exp_f;
    w = v.w;
    wait_idle(w);
    drive(v);
    clear_mon(w);
    exp_f = model_frame(v);
    load_v[w] = 1'b1;
    c0 = cyc;
    k = 0;
    done_k = -1;
    while (k < v.exp_lat + hold + 200) begin
      tick();
      k++;
      if (k == hold) load_v[w] = 1'b0;
      if (edit_at > 0 && k == edit_at) begin
        drive(rand_vec(w));
        load_v[w] = 1'b1;
      end
      if (edit_at > 0 && k == edit_at + 4) load_v[w] = 1'b0;
      if (k == 2) check("busy_after_accept", busy[w], 1'b1);
      if (done_k < 0 && done_n[w] != 0) done_k = k;
      if (done_k >= 0 && k >= done_k + 10 && k > hold + 1) break;
    end
    load_v[w] = 1'b0;
    check("done_seen", done_k >= 0, 1'b1);
    check("done_count", done_n[w], 1);
    check("latency", done_cyc[w] - c0, v.exp_lat);
    check("bit_count", cap_n[w], v.exp_len);
    check_frame("frame", cap_v[w], exp_f);
    check("sr_select", sel[w], v.mode);
    check("rstb_low_cycles", rstb_low[w], rc_arr[w]);
    check("sr_in_stable_ck_high", glitch[w], 0);
    check("busy_in_done", done_busy[w], 1'b0);
    check("idle_ck_in", {ck[w], sin[w]}, 2'b00);
  endtask

  vec_t tbl [8];

  initial begin
    int trig;
    vec_t v;
    load_v[0] = 1'b1;   // held high across reset: must not trigger
    load_v[1] = 1'b0;
    clr[0] = 1'b1; clr[1] = 1'b1;
    v = rand_vec(0);
    drive(v);
    repeat (3) tick();
    clr[0] = 1'b0; clr[1] = 1'b0;
    check("reset_outs_a", outs(0), 6'b110000);
    check("reset_outs_b", outs(1), 6'b110000);
    reset_n = 1'b1;
    trig = 0;
    repeat (20) begin
      tick();
      if (busy[0]) trig++;
    end
    check("held_through_reset_busy", trig, 0);
    check("held_through_reset_done", done_n[0], 0);
    load_v[0] = 1'b0;
    repeat (2) tick();

    tbl[0] = '{w: 0, mode: 1'b1, dac0: 10'h155, dac1: 10'h2AA, dac2: 10'h3FF,
               mask: {192{1'b1}}, ctest: 64'h8000_0000_0000_0001, rr: 64'h0,
               exp_len: 286, exp_lat: 1153};
    tbl[1] = '{w: 0, mode: 1'b0, dac0: 10'h0, dac1: 10'h0, dac2: 10'h0,
               mask: {192{1'b0}}, ctest: 64'h0, rr: 64'h0000_0000_0000_0020,
               exp_len: 64, exp_lat: 265};
    tbl[2] = tbl[0];
    tbl[2].w = 1;
    tbl[2].exp_lat = 574;
    for (int i = 3; i < 8; i++) tbl[i] = rand_vec(int'($urandom_range(0, 1)));

    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i], 4, 0);
      if (i == 1) begin
        check("rr_bit58_set", cap_v[0][285 - 58], 1'b1);
        check("rr_single_one", $countones(cap_v[0]), 1);
      end
    end

    // Request edge while busy, with inputs edited at the same time
    run_frame(tbl[0], 4, 300);
    // Load held for 2000 cycles, then a fresh edge starts a second frame
    run_frame(tbl[3], 2000, 0);
    run_frame(tbl[1], 4, 0);

    // Asynchronous reset 500 cycles into an SC frame
    wait_idle(0);
    drive(tbl[0]);
    clear_mon(0);
    load_v[0] = 1'b1;
    repeat (4) tick();
    load_v[0] = 1'b0;
    repeat (496) tick();
    check("busy_before_mid_reset", busy[0], 1'b1);
    reset_n = 1'b0;
    #1;
    check("reset_mid_outs", outs(0), 6'b110000);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (1200) tick();
    check("reset_mid_no_done", done_n[0], 0);
    run_frame(tbl[0], 4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/microroc_sc_loader.md
Name: microroc_sc_loader

Overview:
- Responder to the controller's slow-control load request: on a rising edge of SCParameterLoad, latches the selected 10-bit DACs, channel mask and CTest channel, then serializes them into the Microroc slow-control or read-register shift chain.
- When the last bit is clocked in, issues the single-cycle MicrorocConfigDone pulse that the sweep and S-curve sequencers wait on.
- Sits between the controller's switcher outputs and the ASIC pins.

Parameters:
- HALF_PERIOD, 2, Clk cycles per SR_CK half-period (SR_CK period = 2*HALF_PERIOD Clk cycles); legal range 1..255.
- RST_CYCLES, 8, Clk cycles SR_RSTB is held low before shifting; legal range 1..255.
- SC_LENGTH, 286, slow-control frame length in bits (fixed by frame layout below).
- RR_LENGTH, 64, read-register frame length in bits.

Ports:
- Clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- SCParameterLoad  in  1  load request, rising-edge triggered
- SCOrReadreg  in  1  1 = slow-control chain, 0 = read-register chain
- Microroc10BitDac0  in  10  DAC0 threshold
- Microroc10BitDac1  in  10  DAC1 threshold
- Microroc10BitDac2  in  10  DAC2 threshold
- MicrorocChannelMask  in  192  discriminator mask, 3 bits per channel
- MicrorocCTestChannel  in  64  CTest enable per channel
- ReadregChannel  in  64  read-register channel select
- SR_SELECT  out  1  chain select to ASIC
- SR_RSTB  out  1  chain reset, active low
- SR_CK  out  1  shift clock
- SR_IN  out  1  serial data
- Busy  out  1  high from accepted request until ConfigDone
- MicrorocConfigDone  out  1  one-Clk pulse at end of frame

Behaviour:
- Reset values: SR_SELECT=1, SR_RSTB=1, SR_CK=0, SR_IN=0, Busy=0, MicrorocConfigDone=0, FSM in IDLE; edge-detect register cleared to 0.
- Request detection: SCParameterLoad is registered once; a request is the condition (current=1 and registered=0).
  - A request is accepted only in IDLE; requests in any other state are dropped, not queued.
  - A level held high through reset does not trigger; it must fall and rise again.
- IDLE: on request, latch all parameter inputs into a shadow frame register, latch the mode, drive SR_SELECT to the mode value, set Busy=1, go to RESET_CHAIN.
- Frame contents:
  - SC frame, first bit shifted first: MicrorocCTestChannel[63:0], MicrorocChannelMask[191:0], Dac2, Dac1, Dac0, each field MSB first. Total 64+192+30 = 286 bits.
  - RR frame: ReadregChannel[63:0], MSB first. Total 64 bits.
- RESET_CHAIN: SR_RSTB=0 for RST_CYCLES Clk cycles, then SR_RSTB=1 and go to SHIFT. A bit counter is loaded with the frame length minus 1.
- SHIFT: one bit per SR_CK period.
  - SR_IN changes only while SR_CK=0, at the first cycle of the low phase.
  - SR_CK is low for HALF_PERIOD cycles, then high for HALF_PERIOD cycles; the ASIC samples on the rising edge.
  - After the high phase of the bit where counter=0, SR_CK returns to 0 and the FSM goes to DONE. Otherwise the counter decrements and the frame shifts left by one.
- DONE: MicrorocConfigDone=1 for exactly one cycle, Busy=0 in that same cycle, SR_IN=0, then go to IDLE.
  - SR_SELECT keeps its value until the next request.
- Latency (request-detect cycle to ConfigDone cycle) = 1 + RST_CYCLES + N*2*HALF_PERIOD.
  - Defaults, SC mode: 1 + 8 + 286*4 = 1153 cycles.
  - Defaults, RR mode: 1 + 8 + 64*4 = 265 cycles.
- Input changes after latching have no effect on the frame in flight.
- Asynchronous reset mid-frame: immediate return to reset values, no ConfigDone.
- The bit counter is 9 bits wide; no wrap-around is possible for legal lengths.

Decomposition:
- Shared package microroc_sc_pkg:
  - FSM state encoding (IDLE, RESET_CHAIN, SHIFT, DONE).
  - SC_LENGTH, RR_LENGTH.
  - Field offsets of the SC frame.
- One sub-module, sc_clk_phase_gen: a HALF_PERIOD counter producing the low/high phase, a "bit start" strobe and a "bit end" strobe, enabled only in SHIFT.

Test Plan:
- SC load, defaults: Dac0=0x155, Dac1=0x2AA, Dac2=0x3FF, mask all 1s, CTest=0x8000_0000_0000_0001 -> capture 286 bits on SR_CK rising edges, equal to the concatenated frame; ConfigDone exactly 1153 cycles after the request.
- RR load: SCOrReadreg=0, ReadregChannel=0x0000_0000_0000_0020 -> SR_SELECT=0, 64 bits captured with a single 1 at shift position 58, ConfigDone at cycle 265.
- Request while Busy: second SCParameterLoad edge at cycle 300 -> ignored; exactly one ConfigDone pulse, and the frame is unchanged by input edits made at cycle 300.
- Load held high for 2000 cycles -> only one frame and one ConfigDone pulse; a falling and then rising edge afterwards starts a second frame.
- reset_n asserted at cycle 500 of an SC frame -> all outputs at reset values within the same cycle, no ConfigDone; a new request afterwards completes normally.
- HALF_PERIOD=1, RST_CYCLES=1 -> SR_CK toggles every cycle, SR_RSTB is low for 1 cycle, SC latency is 1 + 1 + 286*2 = 574 cycles.
